// File: rtl/dual_driver_arbiter.sv
// Round-robin arbiter that time-shares one registered output net between sources A and B.
// Bounded hold time per grant, conflict pulse on simultaneous requests, sticky flag for tied-off requesters.
module dual_driver_arbiter #(
   parameter int WIDTH    = 1,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic             en_a,
   input  logic             en_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic [WIDTH-1:0] out_e,
   output logic             out_valid,
   output logic             conflict,
   output logic             err_empty
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [1:0]       state_q, state_d;
   logic             last_b_q, last_b_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0] out_e_q, out_e_d;
   logic             out_valid_q, out_valid_d;
   logic             conflict_q, conflict_d;
   logic             err_empty_q, err_empty_d;
   logic             ra, rb;

   assign ra = req_a & en_a;
   assign rb = req_b & en_b;

   always_comb begin
      state_d    = state_q;
      conflict_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ra && rb) begin
               state_d    = last_b_q ? OWN_A : OWN_B;
               conflict_d = 1'b1;
            end else if (ra) begin
               state_d = OWN_A;
            end else if (rb) begin
               state_d = OWN_B;
            end
         end
         OWN_A: begin
            if (!ra)                           state_d = rb ? OWN_B : IDLE;
            else if (rb && hold_cnt_q == HOLD_LAST) state_d = OWN_B;
         end
         OWN_B: begin
            if (!rb)                           state_d = ra ? OWN_A : IDLE;
            else if (ra && hold_cnt_q == HOLD_LAST) state_d = OWN_A;
         end
         default: state_d = IDLE;
      endcase
   end

   // Hold counter only runs while the other side is waiting, so an uncontested owner never rotates.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_d != state_q)
         hold_cnt_d = 8'd0;
      else if (((state_q == OWN_A) && rb) || ((state_q == OWN_B) && ra))
         hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 8'd1;
   end

   always_comb begin
      last_b_d    = last_b_q;
      out_e_d     = out_e_q;
      out_valid_d = (state_d != IDLE);
      if (state_d == OWN_A) begin
         out_e_d = data_a;
         if (state_q != OWN_A) last_b_d = 1'b0;
      end else if (state_d == OWN_B) begin
         out_e_d = data_b;
         if (state_q != OWN_B) last_b_d = 1'b1;
      end
      err_empty_d = err_empty_q | (req_a & ~en_a) | (req_b & ~en_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_b_q    <= 1'b1;
         hold_cnt_q  <= 8'd0;
         out_e_q     <= '0;
         out_valid_q <= 1'b0;
         conflict_q  <= 1'b0;
         err_empty_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_b_q    <= last_b_d;
         hold_cnt_q  <= hold_cnt_d;
         out_e_q     <= out_e_d;
         out_valid_q <= out_valid_d;
         conflict_q  <= conflict_d;
         err_empty_q <= err_empty_d;
      end
   end

   assign gnt_a     = (state_q == OWN_A);
   assign gnt_b     = (state_q == OWN_B);
   assign out_e     = out_e_q;
   assign out_valid = out_valid_q;
   assign conflict  = conflict_q;
   assign err_empty = err_empty_q;

endmodule

// File: tb/tb_dual_driver_arbiter.sv
// Directed bench for dual_driver_arbiter: reset, tie/round-robin, uncontested hold, handover, empty port, async reset.
module tb_dual_driver_arbiter;

   localparam int WIDTH    = 8;
   localparam int HOLD_MAX = 4;
   localparam logic [WIDTH-1:0] DA = 8'hA5;
   localparam logic [WIDTH-1:0] DB = 8'h3C;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_a, req_b, en_a, en_b;
   logic [WIDTH-1:0] data_a, data_b;
   logic             gnt_a, gnt_b, out_valid, conflict, err_empty;
   logic [WIDTH-1:0] out_e;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   dual_driver_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
      .data_a(data_a), .data_b(data_b), .en_a(en_a), .en_b(en_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .out_e(out_e), .out_valid(out_valid),
      .conflict(conflict), .err_empty(err_empty)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [WIDTH+4:0] obs;
      rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_a  = 1'($urandom);
         req_b  = 1'($urandom);
         data_a = WIDTH'($urandom);
         data_b = WIDTH'($urandom);
         step();
         obs = {gnt_a, gnt_b, out_e, out_valid, conflict, err_empty};
         chk_cnt++;
         if (obs !== '0) $display("FAIL reset_outputs cyc%0d: got %h want 0", i, obs);
         else pass_cnt++;
      end
      req_a = 1'b0; req_b = 1'b0; data_a = DA; data_b = DB;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         obs = {gnt_a, gnt_b, out_e, out_valid, conflict, err_empty};
         chk_cnt++;
         if (obs !== '0) $display("FAIL idle_after_reset cyc%0d: got %h want 0", i, obs);
         else pass_cnt++;
      end
   endtask

   task automatic test_tie();
      logic             exp_a;
      logic [WIDTH-1:0] exp_e;
      req_a = 1'b1; req_b = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         exp_a = (c <= 4) || (c >= 9);
         exp_e = exp_a ? DA : DB;
         chk_cnt++;
         if ({gnt_a, gnt_b, out_valid} !== {exp_a, ~exp_a, 1'b1})
            $display("FAIL tie_gnt c%0d: got a=%b b=%b v=%b want a=%b b=%b v=1", c, gnt_a, gnt_b, out_valid, exp_a, ~exp_a);
         else pass_cnt++;
         chk_cnt++;
         if (out_e !== exp_e) $display("FAIL tie_out_e c%0d: got %h want %h", c, out_e, exp_e);
         else pass_cnt++;
         chk_cnt++;
         if (conflict !== (c == 1)) $display("FAIL tie_conflict c%0d: got %b want %b", c, conflict, c == 1);
         else pass_cnt++;
      end
      req_a = 1'b0; req_b = 1'b0;
      step();
      chk_cnt++;
      if ({gnt_a, gnt_b, out_valid, out_e} !== {3'b000, DA})
         $display("FAIL tie_release: got a=%b b=%b v=%b e=%h want 0 0 0 %h", gnt_a, gnt_b, out_valid, out_e, DA);
      else pass_cnt++;
   endtask

   task automatic test_uncontested();
      req_a = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk_cnt++;
         if ({gnt_a, gnt_b, out_valid, out_e} !== {3'b101, DA})
            $display("FAIL uncontested c%0d: got a=%b b=%b v=%b e=%h want 1 0 1 %h", c, gnt_a, gnt_b, out_valid, out_e, DA);
         else pass_cnt++;
      end
      req_b = 1'b1;
      for (int k = 1; k <= HOLD_MAX; k++) begin
         step();
         chk_cnt++;
         if ({gnt_a, gnt_b} !== {k != HOLD_MAX, k == HOLD_MAX})
            $display("FAIL contested_rotate k%0d: got a=%b b=%b want a=%b b=%b", k, gnt_a, gnt_b, k != HOLD_MAX, k == HOLD_MAX);
         else pass_cnt++;
      end
      chk_cnt++;
      if ({out_e, conflict} !== {DB, 1'b0})
         $display("FAIL rotate_data: got e=%h conflict=%b want %h 0", out_e, conflict, DB);
      else pass_cnt++;
      req_a = 1'b0; req_b = 1'b0;
      step();
   endtask

   task automatic test_handover();
      req_a = 1'b1;
      step();
      chk_cnt++;
      if ({gnt_a, gnt_b, out_e} !== {2'b10, DA}) $display("FAIL handover_setup: got a=%b b=%b e=%h", gnt_a, gnt_b, out_e);
      else pass_cnt++;
      req_a = 1'b0; req_b = 1'b1;
      step();
      chk_cnt++;
      if ({gnt_a, gnt_b, out_valid, out_e} !== {3'b011, DB})
         $display("FAIL handover: got a=%b b=%b v=%b e=%h want 0 1 1 %h", gnt_a, gnt_b, out_valid, out_e, DB);
      else pass_cnt++;
      req_b = 1'b0;
      step();
   endtask

   task automatic test_empty();
      en_b = 1'b0; req_b = 1'b1; req_a = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk_cnt++;
         if ({gnt_a, gnt_b, out_valid, err_empty} !== 4'b0001)
            $display("FAIL empty_port c%0d: got a=%b b=%b v=%b err=%b want 0 0 0 1", c, gnt_a, gnt_b, out_valid, err_empty);
         else pass_cnt++;
      end
      req_b = 1'b0; req_a = 1'b1;
      step();
      chk_cnt++;
      if ({gnt_a, gnt_b, err_empty, out_e} !== {3'b101, DA})
         $display("FAIL empty_then_a: got a=%b b=%b err=%b e=%h want 1 0 1 %h", gnt_a, gnt_b, err_empty, out_e, DA);
      else pass_cnt++;
      en_a = 1'b0;
      step();
      chk_cnt++;
      if ({gnt_a, gnt_b, out_valid, err_empty} !== 4'b0001)
         $display("FAIL both_disabled: got a=%b b=%b v=%b err=%b want 0 0 0 1", gnt_a, gnt_b, out_valid, err_empty);
      else pass_cnt++;
      req_a = 1'b0; en_a = 1'b1; en_b = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      req_b = 1'b1;
      step();
      chk_cnt++;
      if ({gnt_b, out_valid, out_e} !== {2'b11, DB}) $display("FAIL async_setup: got b=%b v=%b e=%h", gnt_b, out_valid, out_e);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({gnt_a, gnt_b, out_valid, out_e, err_empty} !== '0)
         $display("FAIL async_reset: got a=%b b=%b v=%b e=%h err=%b want all 0", gnt_a, gnt_b, out_valid, out_e, err_empty);
      else pass_cnt++;
      req_a = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      step();
      chk_cnt++;
      if ({gnt_a, gnt_b, conflict, out_e} !== {3'b101, DA})
         $display("FAIL post_reset_tie: got a=%b b=%b c=%b e=%h want 1 0 1 %h", gnt_a, gnt_b, conflict, out_e, DA);
      else pass_cnt++;
      req_a = 1'b0; req_b = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_uncontested();
      test_handover();
      test_empty();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
